ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- EX→MEM pipeline stage that sits directly downstream of the 64-bit ALU.
- Captures the ALU result, NZVC flags and control bundle into a 2-entry skid buffer with a valid/ready handshake.
- Holds the architectural NZVC flag register, updated by flag-setting ops, and resolves LEGv8 B.cond in flight.
- Feeds the MEM stage; applies back-pressure toward EX.

Parameters:
- DATA_W, 64, width of result and store data
- REG_W, 5, destination register index width

Ports:
- clk  input  1  single clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous kill of all buffered entries
- in_valid  input  1  EX has a valid op
- in_ready  output  1  stage can accept this cycle
- in_result  input  DATA_W  ALU result
- in_negative, in_zero, in_overflow, in_carry_out  input  1 each  ALU flags
- in_setflags  input  1  op writes NZVC
- in_is_bcond  input  1  op is B.cond
- in_cond  input  4  LEGv8 condition code
- in_regwrite, in_memread, in_memwrite  input  1 each  control bits
- in_rd  input  REG_W  destination register
- in_store_data  input  DATA_W  STUR data
- out_valid  output  1  MEM-bound entry valid
- out_ready  input  1  MEM accepts
- out_result, out_store_data  output  DATA_W  buffered payload
- out_rd  output  REG_W
- out_regwrite, out_memread, out_memwrite  output  1 each
- out_br_taken  output  1  resolved B.cond outcome; 0 for non-branch
- flags_q  output  4  architectural {N,Z,V,C}

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: both entries invalid. out_valid=0, in_ready=1, flags_q=4'b0000, all payload outputs 0.
- Storage: main entry M drives the outputs; skid entry S is used only when M is stalled.
- in_ready is registered and equals !S.valid, so there is no combinational path from out_ready to in_ready.
- Accept: when in_valid && in_ready. Drain: when out_valid && out_ready. Latency is 1 cycle from accept to out_valid.
- Transitions, by {M.valid, S.valid}:
  - EMPTY → ONE on accept.
  - ONE + accept + drain → ONE, new data in M.
  - ONE + accept, no drain → TWO, new data in S.
  - ONE + drain only → EMPTY.
  - TWO + drain → ONE, S moves to M.
  - TWO never accepts because in_ready=0.
- Payload in M and S is stable while out_valid && !out_ready. Order is preserved.
- Flags: on accept with in_setflags=1, flags_q <= {in_negative, in_zero, in_overflow, in_carry_out} at the next edge. Otherwise flags_q holds.
- Branch resolution: on accept with in_is_bcond=1, out_br_taken for that entry is evaluated against the current flags_q, i.e. flags from all previously accepted ops.
- A single op with both setflags and is_bcond evaluates against the old flags, then updates them.
- Condition codes (N,Z,V,C):
  - 0 EQ Z; 1 NE !Z; 2 HS C; 3 LO !C
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V
  - C GT !Z&(N==V); D LE Z|(N!=V); E,F always 1
- flush:
  - Clears M.valid and S.valid next edge.
  - Drops any same-cycle input; flags are not updated by a dropped op.
  - Flags already committed are kept.
  - in_ready=1 the cycle after.
  - flush overrides a simultaneous accept and drain; the drain handshake still counts as consumed by MEM.
- reset_n asserted mid-operation clears everything immediately, asynchronously; no output glitch is allowed to propagate a valid.

Optional Feature:
- EX_MEM_STALL_CNT_EN:
  - Defined: adds output stall_cnt [31:0]. It increments each cycle with in_valid && !in_ready, saturates at 32'hFFFF_FFFF, resets to 0, and is unaffected by flush.
  - Undefined: the port and counter are absent.

Decomposition:
- Package ex_mem_pkg holds:
  - typedef ex_mem_payload_t, a packed struct of result, store_data, rd, regwrite, memread, memwrite, br_taken.
  - typedef nzcv_t (packed N,Z,V,C).
  - localparams for the 16 condition codes.
- One sub-module, cond_eval: combinational (cond, nzcv_t) → taken.

Test Plan:
- Reset then single op: result=64'h5, rd=3, out_ready=1 → out_valid=1 one cycle after accept, out_result=5, out_rd=3, then out_valid=0.
- Back-pressure: out_ready=0, push ops A=1 then B=2 → in_ready=0 after B. Release out_ready → A, then B, in order, with payload stable while stalled.
- Flags: SUBS with N=0,Z=1,V=0,C=1, then B.cond EQ → flags_q=4'b0101, out_br_taken=1. Same sequence with cond=NE → out_br_taken=0.
- Signed conditions: flags N=1,V=0 then GE → 0, LT → 1. Flags N=1,V=1,Z=0 then GT → 1.
- Flush with buffer full and in_valid=1 carrying setflags N=1 → out_valid=0 next cycle, flags_q unchanged, in_ready=1.
- Async reset mid-stall (TWO state) → out_valid=0 and flags_q=0 immediately while clk is held. With EX_MEM_STALL_CNT_EN, 3 stalled cycles beforehand gives stall_cnt=3, which then clears to 0 on reset.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared types and constants for the EX->MEM pipeline stage.
//   nzcv_t           packed {N,Z,V,C} flag word
//   ex_mem_payload_t buffered entry payload (result, store data, rd, ctrl, br_taken)
//   COND_*           LEGv8 B.cond condition codes
package ex_mem_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int REG_W_DEF  = 5;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_HS = 4'h2;
  localparam logic [3:0] COND_LO = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } nzcv_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] result;
    logic [DATA_W_DEF-1:0] store_data;
    logic [REG_W_DEF-1:0]  rd;
    logic                  regwrite;
    logic                  memread;
    logic                  memwrite;
    logic                  br_taken;
  } ex_mem_payload_t;

endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational LEGv8 B.cond evaluator.
//   cond  [3:0] condition code
//   flags       current {N,Z,V,C}
//   taken       1 when the condition holds (E and F always taken)
module cond_eval
  import ex_mem_pkg::*;
(
  input  logic [3:0] cond,
  input  nzcv_t      flags,
  output logic       taken
);

  always_comb begin
    taken = 1'b1;
    case (cond)
      COND_EQ: taken = flags.z;
      COND_NE: taken = !flags.z;
      COND_HS: taken = flags.c;
      COND_LO: taken = !flags.c;
      COND_MI: taken = flags.n;
      COND_PL: taken = !flags.n;
      COND_VS: taken = flags.v;
      COND_VC: taken = !flags.v;
      COND_HI: taken = flags.c && !flags.z;
      COND_LS: taken = !flags.c || flags.z;
      COND_GE: taken = (flags.n == flags.v);
      COND_LT: taken = (flags.n != flags.v);
      COND_GT: taken = !flags.z && (flags.n == flags.v);
      COND_LE: taken = flags.z || (flags.n != flags.v);
      default: taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline register with a 2-entry skid buffer,
// architectural NZVC flag register and in-flight B.cond resolution.
//   clk, reset_n            clock, async active-low reset
//   flush                   synchronous kill of buffered entries and same-cycle input
//   in_*                    EX-side op (valid/ready handshake, payload, flags, ctrl)
//   out_*                   MEM-side entry (valid/ready handshake, payload, br_taken)
//   flags_q                 architectural {N,Z,V,C}
// Optional build macro EX_MEM_STALL_CNT_EN adds stall_cnt[31:0], a saturating
// count of cycles where EX offered an op but the stage was full.
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  // Payload struct widths come from ex_mem_pkg; keep these equal to them.
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_negative,
  input  logic              in_zero,
  input  logic              in_overflow,
  input  logic              in_carry_out,
  input  logic              in_setflags,
  input  logic              in_is_bcond,
  input  logic [3:0]        in_cond,
  input  logic              in_regwrite,
  input  logic              in_memread,
  input  logic              in_memwrite,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [DATA_W-1:0] in_store_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_regwrite,
  output logic              out_memread,
  output logic              out_memwrite,
  output logic              out_br_taken,
  output logic [3:0]        flags_q
`ifdef EX_MEM_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  ex_mem_payload_t m_q, s_q, in_pl;
  logic            m_valid, s_valid;
  nzcv_t           flags_r;
  logic            cond_taken;
  logic            accept, drain;

  // Branch sees flags_r, i.e. the flags of all earlier accepted ops; a
  // flag-setting B.cond therefore evaluates before its own update lands.
  cond_eval u_cond (
    .cond  (in_cond),
    .flags (flags_r),
    .taken (cond_taken)
  );

  always_comb begin
    in_pl            = '0;
    in_pl.result     = in_result;
    in_pl.store_data = in_store_data;
    in_pl.rd         = in_rd;
    in_pl.regwrite   = in_regwrite;
    in_pl.memread    = in_memread;
    in_pl.memwrite   = in_memwrite;
    in_pl.br_taken   = in_is_bcond && cond_taken;
  end

  // in_ready is s_valid inverted: a flop output, so out_ready never reaches it.
  assign in_ready = !s_valid;
  assign accept   = in_valid && in_ready && !flush;
  assign drain    = m_valid && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_q     <= '0;
      s_q     <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (s_valid) begin
      // TWO: no accept possible; drain promotes skid to main.
      if (drain) begin
        m_q     <= s_q;
        s_valid <= 1'b0;
      end
    end else if (m_valid) begin
      // ONE
      if (accept && drain) begin
        m_q <= in_pl;
      end else if (accept) begin
        s_q     <= in_pl;
        s_valid <= 1'b1;
      end else if (drain) begin
        m_valid <= 1'b0;
      end
    end else if (accept) begin
      // EMPTY
      m_q     <= in_pl;
      m_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      flags_r <= '0;
    else if (accept && in_setflags)
      flags_r <= '{n: in_negative, z: in_zero, v: in_overflow, c: in_carry_out};
  end

`ifdef EX_MEM_STALL_CNT_EN
  // Not cleared by flush; saturates instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stall_cnt <= '0;
    else if (in_valid && !in_ready && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

  assign out_valid      = m_valid;
  assign out_result     = m_q.result;
  assign out_store_data = m_q.store_data;
  assign out_rd         = m_q.rd;
  assign out_regwrite   = m_q.regwrite;
  assign out_memread    = m_q.memread;
  assign out_memwrite   = m_q.memwrite;
  assign out_br_taken   = m_q.br_taken;
  assign flags_q        = flags_r;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed bench for ex_mem_stage with a scoreboard queue.
// Expected entries are pushed when an accept is seen and compared on drain.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_result;
  logic        in_negative, in_zero, in_overflow, in_carry_out;
  logic        in_setflags, in_is_bcond;
  logic [3:0]  in_cond;
  logic        in_regwrite, in_memread, in_memwrite;
  logic [4:0]  in_rd;
  logic [63:0] in_store_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result, out_store_data;
  logic [4:0]  out_rd;
  logic        out_regwrite, out_memread, out_memwrite, out_br_taken;
  logic [3:0]  flags_q;
`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_result      (in_result),
    .in_negative    (in_negative),
    .in_zero        (in_zero),
    .in_overflow    (in_overflow),
    .in_carry_out   (in_carry_out),
    .in_setflags    (in_setflags),
    .in_is_bcond    (in_is_bcond),
    .in_cond        (in_cond),
    .in_regwrite    (in_regwrite),
    .in_memread     (in_memread),
    .in_memwrite    (in_memwrite),
    .in_rd          (in_rd),
    .in_store_data  (in_store_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_store_data (out_store_data),
    .out_rd         (out_rd),
    .out_regwrite   (out_regwrite),
    .out_memread    (out_memread),
    .out_memwrite   (out_memwrite),
    .out_br_taken   (out_br_taken),
    .flags_q        (flags_q)
`ifdef EX_MEM_STALL_CNT_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  typedef struct {
    logic [63:0] result;
    logic [63:0] store;
    logic [4:0]  rd;
    logic        rw, mr, mw, br;
  } exp_t;

  exp_t        exp_q[$];
  logic [3:0]  model_flags = 4'b0000;
  int unsigned model_stall = 0;
  int          vectors = 0;
  int          miscompares = 0;

  // ARM-style encoding: cond[3:1] picks the base test, cond[0] inverts it.
  function automatic logic tb_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, v, cy, base;
    {n, z, v, cy} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return (c[3:1] == 3'd7) ? 1'b1 : (base ^ c[0]);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock: observe handshakes at negedge, then return #1 after posedge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (in_valid && !in_ready) model_stall++;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_result", out_result, e.result);
        chk("sb_store", out_store_data, e.store);
        chk("sb_rd", 64'(out_rd), 64'(e.rd));
        chk("sb_ctrl", 64'({out_regwrite, out_memread, out_memwrite}), 64'({e.rw, e.mr, e.mw}));
        chk("sb_br_taken", 64'(out_br_taken), 64'(e.br));
      end
    end
    if (flush) begin
      exp_q.delete();
    end else if (in_valid && in_ready) begin
      e.result = in_result;
      e.store  = in_store_data;
      e.rd     = in_rd;
      e.rw     = in_regwrite;
      e.mr     = in_memread;
      e.mw     = in_memwrite;
      e.br     = in_is_bcond & tb_cond(in_cond, model_flags);
      exp_q.push_back(e);
      if (in_setflags) model_flags = {in_negative, in_zero, in_overflow, in_carry_out};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] res, input logic [4:0] rd, input logic sf,
                       input logic [3:0] nzcv, input logic bc, input logic [3:0] cond);
    in_valid      = 1'b1;
    in_result     = res;
    in_store_data = res ^ 64'hA5A5_0000_5A5A_FFFF;
    in_rd         = rd;
    in_regwrite   = !bc;
    in_memread    = res[0];
    in_memwrite   = res[1];
    in_setflags   = sf;
    {in_negative, in_zero, in_overflow, in_carry_out} = nzcv;
    in_is_bcond   = bc;
    in_cond       = cond;
  endtask

  task automatic send(input logic [63:0] res, input logic [4:0] rd, input logic sf,
                      input logic [3:0] nzcv, input logic bc, input logic [3:0] cond);
    drive(res, rd, sf, nzcv, bc, cond);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain_all();
    int n = 0;
    out_ready = 1'b1;
    while ((out_valid || exp_q.size() != 0) && n < 20) begin
      tick();
      n++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(64'd0, 5'd0, 1'b0, 4'b0000, 1'b0, 4'h0);
    in_valid = 1'b0;
    in_regwrite = 1'b0;
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_flags", 64'(flags_q), 64'd0);
    chk("rst_result", out_result, 64'd0);
    chk("rst_rd", 64'(out_rd), 64'd0);
`ifdef EX_MEM_STALL_CNT_EN
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // single op, one-cycle latency
    out_ready = 1'b1;
    send(64'h5, 5'd3, 1'b0, 4'b0000, 1'b0, 4'h0);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_result", out_result, 64'h5);
    chk("t1_rd", 64'(out_rd), 64'd3);
    tick();
    chk("t1_empty", 64'(out_valid), 64'd0);

    // back-pressure fills both entries
    out_ready = 1'b0;
    send(64'h1, 5'd1, 1'b0, 4'b0000, 1'b0, 4'h0);
    send(64'h2, 5'd2, 1'b0, 4'b0000, 1'b0, 4'h0);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_head", out_result, 64'h1);
    tick();
    tick();
    chk("bp_hold_valid", 64'(out_valid), 64'd1);
    chk("bp_hold_result", out_result, 64'h1);
    chk("bp_hold_rd", 64'(out_rd), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_second", out_result, 64'h2);
    tick();
    chk("bp_empty", 64'(out_valid), 64'd0);
    chk("bp_ready_back", 64'(in_ready), 64'd1);

    // flags + EQ / NE
    send(64'h7, 5'd4, 1'b1, 4'b0101, 1'b0, 4'h0);
    chk("fl_subs", 64'(flags_q), 64'b0101);
    send(64'h0, 5'd0, 1'b0, 4'b0000, 1'b1, 4'h0);
    chk("fl_eq", 64'(out_br_taken), 64'd1);
    send(64'h7, 5'd4, 1'b1, 4'b0101, 1'b0, 4'h0);
    send(64'h0, 5'd0, 1'b0, 4'b0000, 1'b1, 4'h1);
    chk("fl_ne", 64'(out_br_taken), 64'd0);

    // signed conditions
    send(64'h8, 5'd5, 1'b1, 4'b1000, 1'b0, 4'h0);
    send(64'h0, 5'd0, 1'b0, 4'b0000, 1'b1, 4'hA);
    chk("sg_ge", 64'(out_br_taken), 64'd0);
    send(64'h0, 5'd0, 1'b0, 4'b0000, 1'b1, 4'hB);
    chk("sg_lt", 64'(out_br_taken), 64'd1);
    send(64'h9, 5'd6, 1'b1, 4'b1010, 1'b0, 4'h0);
    send(64'h0, 5'd0, 1'b0, 4'b0000, 1'b1, 4'hC);
    chk("sg_gt", 64'(out_br_taken), 64'd1);
    // setflags + bcond in one op: old flags decide, new flags land
    send(64'h0, 5'd0, 1'b1, 4'b0000, 1'b1, 4'hC);
    chk("combo_taken", 64'(out_br_taken), 64'd1);
    chk("combo_flags", 64'(flags_q), 64'd0);
    send(64'hA, 5'd7, 1'b1, 4'b0011, 1'b0, 4'h0);
    chk("pre_flush_flags", 64'(flags_q), 64'b0011);
    drain_all();

    // flush with buffer full and a flag-setting input pending
    out_ready = 1'b0;
    send(64'h10, 5'd8, 1'b0, 4'b0000, 1'b0, 4'h0);
    send(64'h11, 5'd9, 1'b0, 4'b0000, 1'b0, 4'h0);
    chk("fsh_full", 64'(in_ready), 64'd0);
    drive(64'h12, 5'd10, 1'b1, 4'b1000, 1'b0, 4'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fsh_valid", 64'(out_valid), 64'd0);
    chk("fsh_ready", 64'(in_ready), 64'd1);
    chk("fsh_flags", 64'(flags_q), 64'b0011);
    out_ready = 1'b1;
    tick();
    chk("fsh_stays_empty", 64'(out_valid), 64'd0);

    // async reset while stalled in TWO
    out_ready = 1'b0;
    send(64'h20, 5'd11, 1'b0, 4'b0000, 1'b0, 4'h0);
    send(64'h21, 5'd12, 1'b0, 4'b0000, 1'b0, 4'h0);
    drive(64'h22, 5'd13, 1'b0, 4'b0000, 1'b0, 4'h0);
    tick();
    tick();
    tick();
    chk("ar_two_valid", 64'(out_valid), 64'd1);
`ifdef EX_MEM_STALL_CNT_EN
    chk("ar_stall_cnt", 64'(stall_cnt), 64'(model_stall));
`endif
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_flags", 64'(flags_q), 64'd0);
    chk("ar_ready", 64'(in_ready), 64'd1);
    chk("ar_result", out_result, 64'd0);
`ifdef EX_MEM_STALL_CNT_EN
    chk("ar_stall_clr", 64'(stall_cnt), 64'd0);
`endif
    exp_q.delete();
    model_flags = 4'b0000;
    model_stall = 0;
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // life after reset
    out_ready = 1'b1;
    send(64'h30, 5'd14, 1'b0, 4'b0000, 1'b0, 4'h0);
    chk("post_valid", 64'(out_valid), 64'd1);
    chk("post_result", out_result, 64'h30);
    drain_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
